// File: rtl/wave_capture_pkg.sv
// Shared types and default sizing for the wave_capture oscilloscope capture path.
package wave_capture_pkg;

    typedef enum logic [1:0] {
        ARM       = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2,
        HOLD      = 2'd3
    } state_t;

    localparam int DEPTH_DEFAULT   = 640;
    localparam int AW_DEFAULT      = 10;
    localparam int DW_DEFAULT      = 12;
    localparam int TIMEOUT_DEFAULT = 50000;

    localparam int DECIM_W = 3;
    // Wide enough to count up to 2^7-1 valid samples between kept ones.
    localparam int DCNT_W  = 7;

endpackage

// File: rtl/wave_capture_capture_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port that
// returns 0 for addresses beyond the frame.
module capture_ram #(
    parameter int DEPTH = 640,
    parameter int AW    = 10,
    parameter int DW    = 12
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the output register is reset so the array still maps onto block RAM.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (32'(rd_addr) < DEPTH) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/wave_capture.sv
// Triggered, decimating ADC capture into a one-frame buffer for a VGA scope display.
// Define WAVE_CAPTURE_AUTO_TRIG_EN to enable the timeout auto-trigger.
module wave_capture
    import wave_capture_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int AW      = AW_DEFAULT,
    parameter int DW      = DW_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] sample_data,
    input  logic          sample_valid,
    input  logic [DW-1:0] trig_level,
    input  logic          trig_falling,
    input  logic [2:0]    decim,
    input  logic          frame_done,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          frame_ready,
    output logic          auto_trig
);

    state_t              state, next_state;
    logic [DW-1:0]       level_q, prev_q;
    logic                falling_q;
    logic [DECIM_W-1:0]  decim_q;
    logic [DCNT_W-1:0]   dec_cnt, dec_mask;
    logic                prev_valid;
    logic [AW-1:0]       wr_ptr, wr_addr;
    logic                wr_en, fire, dec_sample, level_hit, timeout_hit;

    // A 7-bit shift of 1 by 7 wraps to 0, so the mask still comes out all ones.
    assign dec_mask   = (DCNT_W'(1) << decim_q) - DCNT_W'(1);
    assign dec_sample = sample_valid && (dec_cnt == '0);
    assign level_hit  = falling_q ? (prev_q > level_q && sample_data <= level_q)
                                  : (prev_q < level_q && sample_data >= level_q);
    assign frame_ready = (state == HOLD);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ARM;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        wr_addr    = wr_ptr;
        fire       = 1'b0;
        case (state)
            ARM: next_state = WAIT_TRIG;
            WAIT_TRIG: begin
                if (dec_sample && prev_valid && (level_hit || timeout_hit)) begin
                    fire       = 1'b1;
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (dec_sample) begin
                    wr_en = 1'b1;
                    if (wr_ptr == AW'(DEPTH - 1)) begin
                        next_state = HOLD;
                    end
                end
            end
            HOLD: begin
                if (frame_done) begin
                    next_state = ARM;
                end
            end
            default: next_state = ARM;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            level_q    <= '0;
            prev_q     <= '0;
            falling_q  <= 1'b0;
            decim_q    <= '0;
            dec_cnt    <= '0;
            prev_valid <= 1'b0;
            wr_ptr     <= '0;
        end else begin
            case (state)
                ARM: begin
                    level_q    <= trig_level;
                    falling_q  <= trig_falling;
                    decim_q    <= decim;
                    dec_cnt    <= '0;
                    prev_valid <= 1'b0;
                    wr_ptr     <= '0;
                end
                WAIT_TRIG: begin
                    if (sample_valid) begin
                        dec_cnt <= (dec_cnt + DCNT_W'(1)) & dec_mask;
                    end
                    if (dec_sample) begin
                        prev_q     <= sample_data;
                        prev_valid <= 1'b1;
                    end
                    if (fire) begin
                        wr_ptr <= AW'(1);
                    end
                end
                CAPTURE: begin
                    if (sample_valid) begin
                        dec_cnt <= (dec_cnt + DCNT_W'(1)) & dec_mask;
                    end
                    if (dec_sample) begin
                        wr_ptr <= wr_ptr + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
    localparam int TW = $clog2(TIMEOUT + 1) + 1;
    logic [TW-1:0] to_cnt;
    logic          auto_q;

    assign timeout_hit = (to_cnt == TW'(TIMEOUT));
    assign auto_trig   = auto_q;

    // Every kept sample in WAIT_TRIG counts, including the one that only loads prev.
    always_ff @(posedge clock) begin
        if (!reset) begin
            to_cnt <= '0;
            auto_q <= 1'b0;
        end else if (state == ARM) begin
            to_cnt <= '0;
            auto_q <= 1'b0;
        end else if (state == WAIT_TRIG) begin
            if (dec_sample && !timeout_hit) begin
                to_cnt <= to_cnt + TW'(1);
            end
            if (fire) begin
                auto_q <= !level_hit;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign auto_trig   = 1'b0;
`endif

    capture_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (sample_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_wave_capture.sv
// Directed self-checking bench for wave_capture; covers the auto-trigger path
// when WAVE_CAPTURE_AUTO_TRIG_EN is defined.
module tb_wave_capture;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic [11:0] trig_level;
    logic        trig_falling;
    logic [2:0]  decim;
    logic        frame_done;
    logic [9:0]  rd_addr;
    logic [11:0] rd_data;
    logic        frame_ready;
    logic        auto_trig;

    int checks = 0;
    int passes = 0;
    logic [11:0] word;

    always #5 clock = ~clock;

    wave_capture #(
        .DEPTH   (640),
        .AW      (10),
        .DW      (12),
        .TIMEOUT (100)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .trig_level   (trig_level),
        .trig_falling (trig_falling),
        .decim        (decim),
        .frame_done   (frame_done),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .frame_ready  (frame_ready),
        .auto_trig    (auto_trig)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; the DUT sees them at the next rising edge.
    task automatic applyStimulus(input logic [11:0] data, input logic valid);
        sample_data  = data;
        sample_valid = valid;
        @(negedge clock);
    endtask

    task automatic readWord(input logic [9:0] addr, output logic [11:0] data);
        rd_addr      = addr;
        sample_valid = 1'b0;
        @(negedge clock);
        data = rd_data;
    endtask

    task automatic pulseDone();
        frame_done   = 1'b1;
        sample_valid = 1'b0;
        @(negedge clock);
        frame_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        sample_data  = '0;
        sample_valid = 1'b0;
        trig_level   = 12'd2048;
        trig_falling = 1'b0;
        decim        = 3'd0;
        frame_done   = 1'b0;
        rd_addr      = '0;
        repeat (2) @(negedge clock);
        checkOutput("reset_frame_ready", frame_ready, 0);
        checkOutput("reset_auto_trig", auto_trig, 0);
        checkOutput("reset_rd_data", rd_data, 0);

        // Rising ramp, step 16, level 2048: trigger on the sample equal to 2048.
        reset = 1'b1;
        applyStimulus(12'd0, 1'b0);
        for (int k = 0; k < 768; k++) begin
            applyStimulus(12'((k * 16) % 4096), 1'b1);
            if (k == 766) checkOutput("ramp_not_ready_early", frame_ready, 0);
        end
        checkOutput("ramp_frame_ready", frame_ready, 1);
        checkOutput("ramp_auto_trig", auto_trig, 0);
        for (int k = 0; k < 3; k++) applyStimulus(12'd77, 1'b1);
        readWord(10'd0, word);   checkOutput("ramp_addr0", word, 2048);
        readWord(10'd1, word);   checkOutput("ramp_addr1", word, 2064);
        readWord(10'd5, word);   checkOutput("ramp_addr5_hold_ignored", word, 2128);
        readWord(10'd639, word); checkOutput("ramp_addr639", word, 4080);
        readWord(10'd640, word); checkOutput("ramp_addr640_oob", word, 0);
        checkOutput("ramp_still_holding", frame_ready, 1);

        // Falling trigger at 1000; a frame_done during capture must be ignored.
        trig_level   = 12'd1000;
        trig_falling = 1'b1;
        pulseDone();
        checkOutput("done_to_arm_not_ready", frame_ready, 0);
        applyStimulus(12'd0, 1'b0);
        applyStimulus(12'd1200, 1'b1);
        applyStimulus(12'd1100, 1'b1);
        applyStimulus(12'd1000, 1'b1);
        for (int a = 1; a < 640; a++) begin
            frame_done = (a == 300);
            applyStimulus(12'(a), 1'b1);
            frame_done = 1'b0;
            if (a == 638) checkOutput("fall_not_ready_early", frame_ready, 0);
        end
        checkOutput("fall_frame_ready", frame_ready, 1);
        readWord(10'd0, word);   checkOutput("fall_addr0", word, 1000);
        readWord(10'd1, word);   checkOutput("fall_addr1", word, 1);
        readWord(10'd300, word); checkOutput("fall_addr300", word, 300);
        readWord(10'd639, word); checkOutput("fall_addr639", word, 639);

        // Decimation by 4: trigger on kept sample i=8, then every 4th sample.
        trig_level   = 12'd2048;
        trig_falling = 1'b0;
        decim        = 3'd2;
        pulseDone();
        applyStimulus(12'd0, 1'b0);
        for (int i = 0; i < 2569; i++) begin
            applyStimulus((i < 8) ? 12'd0 : 12'((2048 + i) % 4096), 1'b1);
            if (i == 2563) checkOutput("decim_not_ready_early", frame_ready, 0);
            if (i == 2564) checkOutput("decim_frame_ready", frame_ready, 1);
        end
        readWord(10'd0, word);   checkOutput("decim_addr0", word, 2056);
        readWord(10'd1, word);   checkOutput("decim_addr1", word, 2060);
        readWord(10'd2, word);   checkOutput("decim_addr2", word, 2064);
        readWord(10'd639, word); checkOutput("decim_addr639", word, 516);

        // Reset with the write pointer at 300 abandons the frame.
        decim = 3'd0;
        pulseDone();
        applyStimulus(12'd0, 1'b0);
        rd_addr = 10'd0;
        for (int k = 0; k < 428; k++) applyStimulus(12'((k * 16) % 4096), 1'b1);
        reset = 1'b0;
        applyStimulus(12'd0, 1'b0);
        checkOutput("midreset_frame_ready", frame_ready, 0);
        checkOutput("midreset_rd_data", rd_data, 0);
        reset = 1'b1;
        applyStimulus(12'd0, 1'b0);
        applyStimulus(12'd100, 1'b1);
        applyStimulus(12'd3000, 1'b1);
        for (int a = 1; a < 640; a++) begin
            applyStimulus(12'd5, 1'b1);
            if (a == 638) checkOutput("restart_not_ready_early", frame_ready, 0);
        end
        checkOutput("restart_frame_ready", frame_ready, 1);
        readWord(10'd0, word);   checkOutput("restart_addr0", word, 3000);
        readWord(10'd1, word);   checkOutput("restart_addr1", word, 5);
        readWord(10'd639, word); checkOutput("restart_addr639", word, 5);

        // Constant 500 never crosses 2048; only the timeout can end WAIT_TRIG.
        pulseDone();
        applyStimulus(12'd0, 1'b0);
`ifdef WAVE_CAPTURE_AUTO_TRIG_EN
        for (int n = 0; n < 740; n++) begin
            applyStimulus(12'd500, 1'b1);
            if (n == 738) checkOutput("auto_not_ready_early", frame_ready, 0);
        end
        checkOutput("auto_frame_ready", frame_ready, 1);
        checkOutput("auto_trig_set", auto_trig, 1);
        readWord(10'd0, word);   checkOutput("auto_addr0", word, 500);
        readWord(10'd639, word); checkOutput("auto_addr639", word, 500);
`else
        for (int n = 0; n < 800; n++) applyStimulus(12'd500, 1'b1);
        checkOutput("noauto_still_waiting", frame_ready, 0);
        checkOutput("noauto_auto_trig", auto_trig, 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 640, samples per captured frame (one per VGA column).
REQ-002 SHALL have parameter AW, default 10, read/write address width.
REQ-003 SHALL have parameter DW, default 12, sample width, matching the ADC parallel output.
REQ-004 SHALL have parameter TIMEOUT, default 50000, decimated samples waited before auto-trigger.
REQ-005 SHALL have port: clock  in  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port: reset  in  1  synchronous, active-low reset.
REQ-007 SHALL have port: sample_data  in  DW  ADC sample, unsigned.
REQ-008 SHALL have port: sample_valid  in  1  one-cycle strobe qualifying sample_data.
REQ-009 SHALL have port: trig_level  in  DW  trigger threshold, unsigned.
REQ-010 SHALL have port: trig_falling  in  1  0 = rising-edge trigger, 1 = falling-edge trigger.
REQ-011 SHALL have port: decim  in  3  keep one of every 2^decim valid samples.
REQ-012 SHALL have port: frame_done  in  1  one-cycle pulse from the display at end of a frame.
REQ-013 SHALL have port: rd_addr  in  AW  display read address.
REQ-014 SHALL have port: rd_data  out  DW  buffer word at rd_addr, registered.
REQ-015 SHALL have port: frame_ready  out  1  high while a complete frame is held.
REQ-016 SHALL have port: auto_trig  out  1  1 = held frame was captured by timeout, not by a level crossing.

Function
REQ-017 SHALL implement the states ARM, WAIT_TRIG, CAPTURE and HOLD.
REQ-018 ARM SHALL last one cycle: latch trig_level, trig_falling and decim; clear the decimation counter, the prev-valid flag and the timeout counter; then go to WAIT_TRIG.
REQ-019 A decimated sample SHALL be the valid sample for which the decimation counter equals 0; the counter SHALL wrap modulo 2^decim.
REQ-020 In WAIT_TRIG, a rising trigger SHALL fire when prev < level and cur >= level; a falling trigger SHALL fire when prev > level and cur <= level.
REQ-021 The first decimated sample after ARM SHALL only load prev and SHALL NOT fire the trigger.
REQ-022 The triggering sample SHALL be written at address 0 in the same cycle; state SHALL go to CAPTURE with the write pointer at 1.
REQ-023 CAPTURE SHALL write each decimated sample at the write pointer and increment it; after the write to DEPTH-1, state SHALL go to HOLD on the next edge.
REQ-024 frame_ready SHALL be 1 exactly in HOLD; in HOLD, sample_valid SHALL be ignored and the buffer SHALL NOT be written.
REQ-025 frame_done SHALL move HOLD to ARM; frame_done SHALL be ignored in every other state.
REQ-026 rd_data SHALL have 1-cycle latency from rd_addr in all states; rd_addr >= DEPTH SHALL return 0.
REQ-027 Changes to trig_level, trig_falling or decim outside ARM SHALL take effect at the next ARM.
REQ-028 Comparisons SHALL be unsigned at DW bits; no arithmetic overflow is possible.

Reset
REQ-029 With reset low at a clock edge: state = ARM, rd_data = 0, frame_ready = 0, auto_trig = 0, and all pointers and counters = 0; buffer contents are undefined.
REQ-030 Reset during CAPTURE or HOLD SHALL abandon the frame; frame_ready SHALL be 0 on the first edge with reset low.

Configuration
REQ-031 With WAVE_CAPTURE_AUTO_TRIG_EN defined: when the timeout counter in WAIT_TRIG reaches TIMEOUT decimated samples, the next decimated sample SHALL be treated as the trigger sample, and auto_trig SHALL be set for that frame.
REQ-032 With WAVE_CAPTURE_AUTO_TRIG_EN undefined: no timeout counter SHALL exist, WAIT_TRIG SHALL wait indefinitely, and auto_trig SHALL be tied to 0.

Structure
REQ-033 A shared package SHALL hold the state enum and the constants DEPTH, AW, DW and TIMEOUT defaults.
REQ-034 The buffer SHALL be one sub-module, capture_ram: simple dual-port, 1 write port and 1 registered read port, inferable as block RAM.

Verification
REQ-035 Rising ramp 0..4095 with step 16, level 2048, decim 0 -> address 0 holds 2048, address 639 holds 2048+639*16 mod 4096, frame_ready = 1 one cycle after the write to 639.
REQ-036 Falling trigger at level 1000, samples 1200, 1100, 1000 -> trigger fires on 1000; 1000 is stored at address 0.
REQ-037 decim = 2 with 2560 valid samples after the trigger -> exactly 640 stored, each being every 4th sample.
REQ-038 Constant input of 500 with level 2048, macro defined, TIMEOUT = 100 -> HOLD reached with auto_trig = 1 and all 640 words = 500; with the macro undefined, state stays in WAIT_TRIG.
REQ-039 frame_done pulsed during CAPTURE, then again in HOLD -> the first pulse is ignored; the second gives ARM next cycle and frame_ready = 0.
REQ-040 reset low at write pointer 300 -> frame_ready = 0 and rd_data = 0; the next capture restarts at address 0.
